// File: rtl/fifo_channel_module_if.sv
// fifo_channel_module_if: token handshake bundle for one KPN FIFO channel.
//   entry_1/entry_valid/entry_ready     : upstream write side
//   output_1/output_valid/output_ready  : downstream read side
//   count/high_water                    : occupancy status
// master = the stages around the channel; slave = the channel itself.
interface fifo_channel_module_if #(
  parameter int CNT_W = 4
);
  logic [15:0]      entry_1;
  logic             entry_valid;
  logic             entry_ready;
  logic [15:0]      output_1;
  logic             output_valid;
  logic             output_ready;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] high_water;

  modport master (
    output entry_1, entry_valid, output_ready,
    input  entry_ready, output_1, output_valid, count, high_water
  );

  modport slave (
    input  entry_1, entry_valid, output_ready,
    output entry_ready, output_1, output_valid, count, high_water
  );
endinterface

// File: rtl/fifo_channel_module.sv
// fifo_channel_module: blocking in-order FIFO channel for 16-bit tokens
// between two KPN stages, with occupancy and high-watermark reporting.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high
//   bus   - slave side of fifo_channel_module_if (write/read handshakes,
//           count, high_water)
// The head token is held in its own register so output_1 never comes from
// a combinational memory read.
module fifo_channel_module #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic                  clk,
  input logic                  reset,
  fifo_channel_module_if.slave bus
);
  localparam int               PTR_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

  logic [15:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] hw_r;
  logic [15:0]      head_r;

  logic             entry_ready_s;
  logic             output_valid_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [15:0]      head_nxt_s;

  // Handshake decode from registered count only.
  always_comb begin
    entry_ready_s  = !reset && (count_r != FULL_C);
    output_valid_s = (count_r != ZERO_C);
    wr_en_s        = bus.entry_valid && entry_ready_s;
    rd_en_s        = output_valid_s && bus.output_ready;
    // Slot after the current head; pointer wraps modulo DEPTH naturally.
    rd_ptr_nxt_s   = rd_ptr_r + PTR_W'(1);
  end

  // Next occupancy and next head token for each write/read combination.
  always_comb begin
    count_nxt_s = count_r;
    head_nxt_s  = head_r;
    case ({wr_en_s, rd_en_s})
      2'b10: begin
        count_nxt_s = count_r + ONE_C;
        // Writing into an empty channel makes the new token the head.
        if (count_r == ZERO_C) begin
          head_nxt_s = bus.entry_1;
        end else begin
          head_nxt_s = head_r;
        end
      end
      2'b01: begin
        count_nxt_s = count_r - ONE_C;
        // Stale when the last token leaves, but output_valid is low then.
        head_nxt_s  = mem_r[rd_ptr_nxt_s];
      end
      2'b11: begin
        count_nxt_s = count_r;
        // With one token stored the incoming token is the only successor.
        if (count_r == ONE_C) begin
          head_nxt_s = bus.entry_1;
        end else begin
          head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
      end
      default: begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
      end
    endcase
  end

  // Token storage; contents are meaningless until covered by count.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= bus.entry_1;
    end
  end

  // Pointers, occupancy, head register and high-watermark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      hw_r     <= '0;
      head_r   <= 16'h0000;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      count_r <= count_nxt_s;
      head_r  <= head_nxt_s;
      if (count_nxt_s > hw_r) begin
        hw_r <= count_nxt_s;
      end
    end
  end

  assign bus.entry_ready  = entry_ready_s;
  assign bus.output_valid = output_valid_s;
  assign bus.output_1     = head_r;
  assign bus.count        = count_r;
  assign bus.high_water   = hw_r;
endmodule

// File: tb/tb_fifo_channel_module.sv
// tb_fifo_channel_module: directed vector table plus hand-written sequences
// (async reset mid-stream, streaming with wrap, random backpressure with a
// queue scoreboard) for fifo_channel_module at DEPTH = 8.
module tb_fifo_channel_module;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  typedef struct {
    logic        ev;
    logic [15:0] d;
    logic        ordy;
    int          cnt;
    logic        vld;
    logic [15:0] out;
    logic        rdy;
    int          hw;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fifo_channel_module_if #(.CNT_W(CNT_W)) bus ();

  fifo_channel_module #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ev, input logic [15:0] d, input logic ordy,
                     input int cnt, input logic vld, input logic [15:0] out,
                     input logic rdy, input int hw);
    vec_t v;
    v.ev = ev; v.d = d; v.ordy = ordy; v.cnt = cnt;
    v.vld = vld; v.out = out; v.rdy = rdy; v.hw = hw;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic ev, input logic [15:0] d, input logic ordy);
    bus.entry_valid  = ev;
    bus.entry_1      = d;
    bus.output_ready = ordy;
  endtask

  // Watchdog: the bench never runs unbounded.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] q[$];
    int          m_hw;
    logic        ev, ordy, wr, rd;
    logic [15:0] d;

    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    chk("rst_count", bus.count, 0);
    chk("rst_valid", bus.output_valid, 0);
    chk("rst_ready", bus.entry_ready, 0);
    chk("rst_out",   bus.output_1, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", bus.entry_ready, 1);

    // Single token, fill to full, read+write at full, drain, held inputs,
    // simultaneous read/write at count = 1.
    add(1, 16'h00F0, 0, 1, 1, 16'h00F0, 1, 1);
    add(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      add(1, 16'(k), 0, k, 1, 16'h0001, (k != 8), (k > 1) ? k : 1);
    end
    add(1, 16'h0009, 0, 8, 1, 16'h0001, 0, 8);
    add(1, 16'h0009, 1, 7, 1, 16'h0002, 1, 8);
    add(1, 16'h000A, 1, 7, 1, 16'h0003, 1, 8);
    add(0, 16'h0000, 1, 6, 1, 16'h0004, 1, 8);
    add(0, 16'h0000, 1, 5, 1, 16'h0005, 1, 8);
    add(0, 16'h0000, 1, 4, 1, 16'h0006, 1, 8);
    add(0, 16'h0000, 1, 3, 1, 16'h0007, 1, 8);
    add(0, 16'h0000, 1, 2, 1, 16'h0008, 1, 8);
    add(0, 16'h0000, 1, 1, 1, 16'h000A, 1, 8);
    add(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 8);
    add(0, 16'hBEEF, 1, 0, 0, 16'h0000, 1, 8);
    add(1, 16'h0011, 0, 1, 1, 16'h0011, 1, 8);
    add(1, 16'h0022, 1, 1, 1, 16'h0022, 1, 8);
    add(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 8);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].ev, tbl[i].d, tbl[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), bus.count, tbl[i].cnt);
      chk($sformatf("vec%0d_valid", i), bus.output_valid, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("vec%0d_out", i), bus.output_1, tbl[i].out);
      chk($sformatf("vec%0d_ready", i), bus.entry_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_hw", i), bus.high_water, tbl[i].hw);
    end

    // Asynchronous reset with five tokens stored.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b1, 16'h0100 + 16'(k), 1'b0);
    end
    @(negedge clk);
    drive(1'b1, 16'h0200, 1'b0);
    #2;
    chk("pre_rst_count", bus.count, 5);
    reset = 1'b1;
    #1;
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_hw",    bus.high_water, 0);
    chk("async_rst_valid", bus.output_valid, 0);
    chk("async_rst_out",   bus.output_1, 16'h0000);
    chk("async_rst_ready", bus.entry_ready, 0);
    @(posedge clk); #1;
    chk("held_rst_count", bus.count, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    #1;
    chk("post_rst_ready", bus.entry_ready, 1);

    // Streaming: read and write every cycle, output lags input by one edge.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(1'b1, 16'h1000 + 16'(i), 1'b1);
      @(posedge clk); #1;
      chk($sformatf("stream%0d_out", i), bus.output_1, 16'h1000 + 16'(i));
      chk($sformatf("stream%0d_count", i), bus.count, 1);
    end
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b1);
    @(posedge clk); #1;
    chk("stream_end_count", bus.count, 0);
    chk("stream_hw", bus.high_water, 1);

    // Random backpressure against a queue scoreboard.
    m_hw = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      chk("rnd_valid", bus.output_valid, (q.size() != 0));
      if (q.size() != 0) chk("rnd_out", bus.output_1, q[0]);
      chk("rnd_count", bus.count, q.size());
      chk("rnd_range", (bus.count <= 4'd8), 1);
      chk("rnd_ready", bus.entry_ready, (q.size() != DEPTH));
      ev   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 2) != 0 ? 1 : 0) & 1'($urandom_range(0, 1));
      d    = 16'($urandom);
      drive(ev, d, ordy);
      wr = ev && (q.size() != DEPTH);
      rd = ordy && (q.size() != 0);
      @(posedge clk);
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(d);
      if (q.size() > m_hw) m_hw = q.size();
    end
    // Drain what remains and confirm nothing was lost.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (q.size() != 0) chk("drain_out", bus.output_1, q[0]);
      drive(1'b0, 16'h0000, 1'b1);
      @(posedge clk);
      if (q.size() != 0) void'(q.pop_front());
    end
    #1;
    chk("drain_count", bus.count, 0);
    chk("rnd_hw", bus.high_water, m_hw);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
